// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline register: valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
module mem_wb_pipe_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CTRL_W = 2,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl_wb,
    input  logic [REG_W-1:0]  in_reg_dst,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl_wb,
    output logic [REG_W-1:0]  out_reg_dst,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_rdata,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bp_cycles
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rdata;
    } entry_t;

    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    entry_t           head_q;
    entry_t           skid_q;
    entry_t           in_entry;
    logic             h_valid;
    logic             s_valid;
    logic             accept;
    logic             consume;
    logic             load_head_in;
    logic             load_head_skid;
    logic             load_skid;
    logic [CNT_W-1:0] bp_q;

    assign in_entry = '{ctrl: in_ctrl_wb, dst: in_reg_dst, alu: in_alu_result, rdata: in_mem_rdata};

    assign h_valid = (state != EMPTY);
    assign s_valid = (state == TWO);

    // Skid mode decouples in_ready from out_ready; single-entry mode passes it through.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = rst & ~s_valid;
        end else begin : g_flat_ready
            assign in_ready = rst & (~h_valid | out_ready);
        end
    endgenerate

    assign accept  = in_valid & in_ready;
    assign consume = h_valid & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and storage load selects; flush overrides any transfer.
    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_head_in = 1'b1;
                        state_nxt    = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_head_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_nxt = TWO;
                    end else if (consume) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        load_head_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Entry storage; contents persist while invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_head_in) begin
                head_q <= in_entry;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    // Saturating count of stalled cycles; flush leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bp_q <= '0;
        end else if (h_valid && !out_ready && (bp_q != {CNT_W{1'b1}})) begin
            bp_q <= bp_q + CNT_W'(1);
        end
    end

    assign out_valid   = h_valid;
    assign out_ctrl_wb = h_valid ? head_q.ctrl : '0;
    assign out_reg_dst = head_q.dst;
    assign out_result  = head_q.alu;
    assign out_rdata   = head_q.rdata;
    assign occupancy   = state;
    assign bp_cycles   = bp_q;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: a flat-FIFO model checks a single-entry and a skid
// instance every cycle, plus directed literal checks.
module tb_mem_wb_pipe_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 2;
    localparam int unsigned BW = 4;
    localparam int unsigned EW = CW + RW + 2 * DW;
    localparam int          BPMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [RW-1:0] in_dst = '0;
    logic [DW-1:0] in_alu = '0;
    logic [DW-1:0] in_rdata = '0;

    // Index 0: SKID=0, index 1: SKID=1.
    logic [1:0]         iv = '0;
    logic [1:0]         ordy = '0;
    logic [1:0]         ir;
    logic [1:0]         ov;
    logic [1:0][CW-1:0] octrl;
    logic [1:0][RW-1:0] odst;
    logic [1:0][DW-1:0] ores;
    logic [1:0][DW-1:0] ordata;
    logic [1:0][1:0]    occ;
    logic [1:0][BW-1:0] bp;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_stage #(.DATA_W(DW), .REG_W(RW), .CTRL_W(CW), .SKID(0), .CNT_W(BW)) u_flat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .in_ctrl_wb(in_ctrl), .in_reg_dst(in_dst), .in_alu_result(in_alu), .in_mem_rdata(in_rdata),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_ctrl_wb(octrl[0]), .out_reg_dst(odst[0]), .out_result(ores[0]), .out_rdata(ordata[0]),
        .occupancy(occ[0]), .bp_cycles(bp[0])
    );

    mem_wb_pipe_stage #(.DATA_W(DW), .REG_W(RW), .CTRL_W(CW), .SKID(1), .CNT_W(BW)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .in_ctrl_wb(in_ctrl), .in_reg_dst(in_dst), .in_alu_result(in_alu), .in_mem_rdata(in_rdata),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_ctrl_wb(octrl[1]), .out_reg_dst(odst[1]), .out_result(ores[1]), .out_rdata(ordata[1]),
        .occupancy(occ[1]), .bp_cycles(bp[1])
    );

    // Model: everything ever accepted, with a read pointer; held entries are wr-rd.
    logic [EW-1:0] mq [2][1024];
    int            wr [2] = '{0, 0};
    int            rd [2] = '{0, 0};
    int            mbp [2] = '{0, 0};
    logic [EW-1:0] last_head [2] = '{'0, '0};

    function automatic int m_occ(input int i);
        return wr[i] - rd[i];
    endfunction

    function automatic logic m_ready(input int i);
        if (!rst) return 1'b0;
        if (i == 1) return m_occ(i) < 2;
        return (m_occ(i) == 0) || ordy[i];
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                rd[i] = wr[i];
                mbp[i] = 0;
                last_head[i] = '0;
            end else begin
                logic acc;
                logic con;
                acc = iv[i] && m_ready(i);
                con = (m_occ(i) > 0) && ordy[i];
                if ((m_occ(i) > 0) && !ordy[i] && (mbp[i] < BPMAX)) mbp[i]++;
                if (flush) begin
                    rd[i] = wr[i];
                end else begin
                    if (con) rd[i]++;
                    if (acc) begin
                        mq[i][wr[i] % 1024] = {in_ctrl, in_dst, in_alu, in_rdata};
                        wr[i]++;
                    end
                end
                if (m_occ(i) > 0) last_head[i] = mq[i][rd[i] % 1024];
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d got=%0h want=%0h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic          v;
            logic [EW-1:0] h;
            v = m_occ(i) > 0;
            h = v ? mq[i][rd[i] % 1024] : last_head[i];
            chk("in_ready", i, EW'(ir[i]), EW'(m_ready(i)));
            chk("out_valid", i, EW'(ov[i]), EW'(v));
            chk("out_ctrl_wb", i, EW'(octrl[i]), v ? EW'(h[EW-1 -: CW]) : EW'(0));
            chk("out_reg_dst", i, EW'(odst[i]), EW'(h[2*DW +: RW]));
            chk("out_result", i, EW'(ores[i]), EW'(h[DW +: DW]));
            chk("out_rdata", i, EW'(ordata[i]), EW'(h[DW-1:0]));
            chk("occupancy", i, EW'(occ[i]), EW'(m_occ(i)));
            chk("bp_cycles", i, EW'(bp[i]), EW'(mbp[i]));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic put(input logic [CW-1:0] c, input logic [RW-1:0] d,
                       input logic [DW-1:0] a, input logic [DW-1:0] r);
        in_ctrl = c;
        in_dst = d;
        in_alu = a;
        in_rdata = r;
    endtask

    initial begin
        int s0;
        int s1;
        int n;
        #2 rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;

        // Single transfer, 1-cycle latency, then consumed.
        ordy = 2'b11;
        put(2'b11, 5'd9, 32'h1234, 32'hcafe);
        iv = 2'b11;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("t1_valid", i, EW'(ov[i]), EW'(1));
            chk("t1_ctrl", i, EW'(octrl[i]), EW'(2'b11));
            chk("t1_dst", i, EW'(odst[i]), EW'(5'd9));
            chk("t1_alu", i, EW'(ores[i]), EW'(32'h1234));
            chk("t1_occ", i, EW'(occ[i]), EW'(1));
        end
        iv = 2'b00;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("t1_occ_after", i, EW'(occ[i]), EW'(0));
            chk("t1_ctrl_bubble", i, EW'(octrl[i]), EW'(0));
            chk("t1_dst_held", i, EW'(odst[i]), EW'(5'd9));
        end

        // Skid fill under stall, then drain in order.
        ordy = 2'b00;
        put(2'b01, 5'd3, 32'ha1, 32'ha2);
        iv = 2'b11;
        step();
        put(2'b10, 5'd4, 32'hb1, 32'hb2);
        step();
        chk("t2_occ", 1, EW'(occ[1]), EW'(2));
        chk("t2_in_ready", 1, EW'(ir[1]), EW'(0));
        chk("t2_bp1", 1, EW'(bp[1]), EW'(1));
        iv = 2'b00;
        step();
        chk("t2_bp2", 1, EW'(bp[1]), EW'(2));
        ordy = 2'b11;
        #1;
        chk("t2_first_A", 1, EW'(odst[1]), EW'(5'd3));
        step();
        chk("t2_second_B", 1, EW'(odst[1]), EW'(5'd4));
        chk("t2_ctrl_B", 1, EW'(octrl[1]), EW'(2'b10));
        chk("t2_occ1", 1, EW'(occ[1]), EW'(1));
        step();
        chk("t2_occ0", 1, EW'(occ[1]), EW'(0));
        chk("t2_bp_hold", 1, EW'(bp[1]), EW'(2));

        // Flush with a full skid and a new entry offered.
        ordy = 2'b00;
        put(2'b01, 5'd10, 32'h10, 32'h11);
        iv = 2'b11;
        step();
        put(2'b10, 5'd11, 32'h20, 32'h21);
        step();
        flush = 1'b1;
        put(2'b11, 5'd12, 32'h30, 32'h31);
        step();
        flush = 1'b0;
        iv = 2'b00;
        chk("t4_occ", 1, EW'(occ[1]), EW'(0));
        chk("t4_valid", 1, EW'(ov[1]), EW'(0));
        chk("t4_ctrl", 1, EW'(octrl[1]), EW'(0));
        step();
        for (int i = 0; i < 2; i++) chk("t4_not_stored", i, EW'(occ[i]), EW'(0));

        // Random streams on both instances.
        s0 = wr[0];
        s1 = wr[1];
        n = 0;
        while (((wr[0] - s0) < 100 || (wr[1] - s1) < 100) && n < 3000) begin
            iv = 2'($urandom);
            ordy = 2'($urandom);
            put(CW'($urandom), RW'($urandom), $urandom, $urandom);
            step();
            n++;
        end
        chk("t3_count_flat", 0, EW'((wr[0] - s0) >= 100), EW'(1));
        chk("t3_count_skid", 1, EW'((wr[1] - s1) >= 100), EW'(1));
        iv = 2'b00;
        ordy = 2'b11;
        repeat (3) step();
        for (int i = 0; i < 2; i++) chk("t3_drained", i, EW'(occ[i]), EW'(0));

        // Asynchronous reset with entries in flight.
        ordy = 2'b00;
        put(2'b11, 5'd7, 32'h77, 32'h78);
        iv = 2'b11;
        step();
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("t6_valid", i, EW'(ov[i]), EW'(0));
            chk("t6_ctrl", i, EW'(octrl[i]), EW'(0));
            chk("t6_occ", i, EW'(occ[i]), EW'(0));
            chk("t6_bp", i, EW'(bp[i]), EW'(0));
            chk("t6_in_ready", i, EW'(ir[i]), EW'(0));
        end
        iv = 2'b00;
        step();
        rst = 1'b1;

        // Counter saturation at 15 with a 4-bit counter.
        put(2'b01, 5'd1, 32'h1, 32'h2);
        iv = 2'b11;
        step();
        iv = 2'b00;
        repeat (10) step();
        for (int i = 0; i < 2; i++) chk("t5_bp10", i, EW'(bp[i]), EW'(10));
        repeat (10) step();
        for (int i = 0; i < 2; i++) chk("t5_bp_sat", i, EW'(bp[i]), EW'(15));

        ordy = 2'b11;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
